// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// hands each fetched instruction to decode, honouring downstream branch redirects.
module fetch_unit #(
  parameter int unsigned     WORD      = 64,
  parameter int unsigned     INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD-1:0]      imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [INSTR_LEN-1:0] imem_resp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      instr_pc,
  input  logic                 redirect_valid,
  input  logic [WORD-1:0]      branch_pc,
  input  logic [WORD-1:0]      branch_offset
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]           r_state;
  logic [WORD-1:0]      r_pc;
  logic                 r_drop;
  logic [INSTR_LEN-1:0] r_instr;
  logic [WORD-1:0]      r_instr_pc;

  logic [1:0]           w_state_nxt;
  logic [WORD-1:0]      w_pc_nxt;
  logic                 w_drop_nxt;
  logic [INSTR_LEN-1:0] w_instr_nxt;
  logic [WORD-1:0]      w_instr_pc_nxt;

  logic [WORD-1:0]      w_target;
  logic [WORD-1:0]      w_pc_inc;
  logic                 w_req_fire;

  // Word offset scaled to bytes; the shift discards the top two offset bits.
  assign w_target   = branch_pc + (branch_offset << 2);
  assign w_pc_inc   = r_pc + WORD'(4);

  assign imem_req_valid = rst_n && (r_state == S_FETCH);
  assign imem_req_addr  = r_pc;
  assign instr_valid    = (r_state == S_OUT);
  assign instruction    = r_instr;
  assign instr_pc       = r_instr_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
    end
  end

  // Next-state logic; a redirect always overrides the sequential pc+4
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    case (r_state)
      S_FETCH: begin
        if (w_req_fire) begin
          w_state_nxt = S_WAIT;
          if (redirect_valid) w_drop_nxt = 1'b1;
        end
        if (redirect_valid) w_pc_nxt = w_target;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_state_nxt = S_FETCH;
          w_drop_nxt  = 1'b0;
          if (redirect_valid) begin
            w_pc_nxt = w_target;
          end else if (!r_drop) begin
            w_instr_nxt    = imem_resp_data;
            w_instr_pc_nxt = r_pc;
            w_pc_nxt       = w_pc_inc;
            w_state_nxt    = S_OUT;
          end
        end else if (redirect_valid) begin
          w_pc_nxt   = w_target;
          w_drop_nxt = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (instr_ready) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, delivery scoreboard,
// a redirect vector table and hand-written corner sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_resp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] branch_pc, branch_offset;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .branch_pc(branch_pc), .branch_offset(branch_offset)
  );

  // Second instance with overridden reset PC, driven by hand
  logic        a_rst_n, a_req_valid, a_req_ready, a_resp_valid, a_instr_valid, a_instr_ready;
  logic [63:0] a_req_addr, a_instr_pc;
  logic [31:0] a_resp_data, a_instruction;
  logic        a_redirect;
  logic [63:0] a_bpc, a_boff;

  fetch_unit #(.RESET_PC(64'h400)) u_alt (
    .clk(clk), .rst_n(a_rst_n),
    .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_req_addr(a_req_addr),
    .imem_resp_valid(a_resp_valid), .imem_resp_data(a_resp_data),
    .instr_valid(a_instr_valid), .instr_ready(a_instr_ready), .instruction(a_instruction),
    .instr_pc(a_instr_pc),
    .redirect_valid(a_redirect), .branch_pc(a_bpc), .branch_offset(a_boff)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A3C_0000;
  endfunction

  // Memory model: acts 1 time unit after each falling edge
  bit          mem_ready_cfg = 1'b1;
  int          mem_lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [63:0] mem_addr = '0;

  always @(negedge clk) begin
    #1;
    imem_resp_valid = 1'b0;
    if (mem_busy) begin
      if (mem_wait <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_busy        = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    imem_req_ready = mem_ready_cfg && !mem_busy;
    if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_wait = mem_lat;
    end
  end

  // Delivery scoreboard
  typedef struct packed { logic [63:0] pc; logic [31:0] ins; } exp_t;
  exp_t sb[$];
  int   hs_cyc[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (rst_n && instr_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_instr: got pc %h instr %h, nothing expected", instr_pc, instruction);
      end else if (instr_ready) begin
        check("deliver_pc", instr_pc, sb[0].pc);
        check("deliver_instr", 64'(instruction), 64'(sb[0].ins));
        void'(sb.pop_front());
        hs_cyc.push_back(cyc);
      end
    end
  end

  function automatic bit st_is(input int what);
    case (what)
      0:       return imem_req_valid;
      1:       return !imem_req_valid && !instr_valid;
      default: return instr_valid;
    endcase
  endfunction

  task automatic wait_for(input int what, input string name);
    int n = 0;
    while (!st_is(what) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin n_chk++; $display("FAIL timeout_%s: state not reached, required within 60 cycles", name); end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin n_chk++; $display("FAIL timeout_%s: %0d pending, required 0", name, sb.size()); end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic pulse_redirect(input logic [63:0] bpc, input logic [63:0] off);
    redirect_valid = 1'b1;
    branch_pc      = bpc;
    branch_offset  = off;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  typedef struct { logic [63:0] bpc; logic [63:0] off; logic [63:0] tgt; } redir_vec_t;

  initial begin
    redir_vec_t vecs[5];
    vecs[0] = '{64'h1000, 64'h4, 64'h1010};
    vecs[1] = '{64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFC};
    vecs[2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h8, 64'h10};
    vecs[4] = '{64'h40, 64'h4000_0000_0000_0001, 64'h44};

    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
    branch_pc = '0; branch_offset = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    a_rst_n = 1'b0; a_req_ready = 1'b0; a_resp_valid = 1'b0; a_resp_data = '0;
    a_instr_ready = 1'b0; a_redirect = 1'b0; a_bpc = '0; a_boff = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_instr_pc", instr_pc, 64'd0);
    for (int i = 0; i < 4; i++) push_exp(64'(4 * i));
    rst_n = 1'b1;
    #1;
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", imem_req_addr, 64'd0);
    check("first_instr_valid", 64'(instr_valid), 64'd0);

    // Straight-line delivery at 0,4,8, one every 3 cycles
    begin
      int n = 0;
      while (hs_cyc.size() < 3 && n < 60) begin @(negedge clk); n++; end
      if (n >= 60) begin n_chk++; $display("FAIL timeout_straight: %0d delivered, required 3", hs_cyc.size()); end
    end
    instr_ready = 1'b0;
    if (hs_cyc.size() >= 3) begin
      check("spacing_0_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
      check("spacing_1_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
    end

    // Decode backpressure on pc 0xC
    wait_for(2, "bp_out");
    for (int i = 0; i < 5; i++) begin
      check("bp_instr_pc", instr_pc, 64'hC);
      check("bp_instruction", 64'(instruction), 64'(mem_word(64'hC)));
      check("bp_no_req", 64'(imem_req_valid), 64'd0);
      @(negedge clk);
    end
    mem_lat = 3;
    instr_ready = 1'b1;
    @(negedge clk);
    check("bp_release_addr", imem_req_addr, 64'h10);
    check("bp_release_req", 64'(imem_req_valid), 64'd1);

    // Redirect while waiting on the 0x10 response: it must be dropped
    @(negedge clk);
    check("wait_state", 64'(st_is(1)), 64'd1);
    push_exp(64'h0);
    pulse_redirect(64'h10, 64'hFFFF_FFFF_FFFF_FFFC);
    mem_lat = 1;
    check("drop_still_wait", 64'(st_is(1)), 64'd1);
    wait_for(0, "drop_fetch");
    check("drop_next_addr", imem_req_addr, 64'h0);
    wait_drain("drop_deliver");

    // Redirect coincident with a response
    wait_for(1, "coinc_wait");
    check("coinc_resp_seen", 64'(st_is(1)), 64'd1);
    push_exp(64'h140);
    pulse_redirect(64'h100, 64'h10);
    check("coinc_req_valid", 64'(imem_req_valid), 64'd1);
    check("coinc_addr", imem_req_addr, 64'h140);

    // Redirect in OUT while decode takes the instruction
    wait_for(2, "out_ready");
    push_exp(64'h204);
    pulse_redirect(64'h200, 64'h1);
    check("out_rdy_valid", 64'(instr_valid), 64'd0);
    check("out_rdy_addr", imem_req_addr, 64'h204);
    instr_ready = 1'b0;

    // Redirect in OUT without ready: held instruction is flushed
    for (int i = 0; i < 5; i++) begin
      wait_for(2, "flush_out");
      if (sb.size() != 0) begin
        check("flush_held_pc", instr_pc, sb[0].pc);
        void'(sb.pop_front());
      end
      push_exp(vecs[i].tgt);
      pulse_redirect(vecs[i].bpc, vecs[i].off);
      check("flush_valid_low", 64'(instr_valid), 64'd0);
      check("flush_target", imem_req_addr, vecs[i].tgt);
    end

    // Fetch at the top of the address space, then pc wraps to 0
    wait_for(2, "wrap_out");
    if (sb.size() != 0) void'(sb.pop_front());
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    pulse_redirect(64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    instr_ready = 1'b1;
    wait_drain("wrap_deliver");
    check("wrap_next_addr", imem_req_addr, 64'h0);
    push_exp(64'h0);
    wait_drain("wrap_zero");
    mem_ready_cfg = 1'b0;

    // Redirect in FETCH without handshake, then with handshake
    @(negedge clk);
    check("fetch_stall_addr", imem_req_addr, 64'h4);
    pulse_redirect(64'h800, 64'h2);
    check("fetch_redir_addr", imem_req_addr, 64'h808);
    push_exp(64'h808);
    mem_ready_cfg = 1'b1;
    wait_drain("fetch_redir_deliver");
    check("fetch_hs_addr", imem_req_addr, 64'h80C);
    push_exp(64'h900);
    pulse_redirect(64'h900, 64'h0);
    check("fetch_hs_wait", 64'(st_is(1)), 64'd1);
    wait_drain("fetch_hs_deliver");
    mem_ready_cfg = 1'b0;

    // Reset while waiting, then a late response on the RESET_PC=0x400 instance
    a_rst_n = 1'b1; a_req_ready = 1'b1;
    #1;
    check("alt_first_req", 64'(a_req_valid), 64'd1);
    check("alt_first_addr", a_req_addr, 64'h400);
    @(negedge clk);
    a_req_ready = 1'b0;
    check("alt_in_wait", 64'(a_req_valid), 64'd0);
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    #1;
    check("alt_restart_req", 64'(a_req_valid), 64'd1);
    check("alt_restart_addr", a_req_addr, 64'h400);
    a_resp_valid = 1'b1; a_resp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    a_resp_valid = 1'b0;
    check("alt_late_ignored", 64'(a_instr_valid), 64'd0);
    check("alt_still_fetch", 64'(a_req_valid), 64'd1);
    a_req_ready = 1'b1;
    @(negedge clk);
    a_req_ready = 1'b0;
    a_resp_valid = 1'b1; a_resp_data = 32'h1234_5678;
    @(negedge clk);
    a_resp_valid = 1'b0;
    check("alt_valid", 64'(a_instr_valid), 64'd1);
    check("alt_instruction", 64'(a_instruction), 64'h1234_5678);
    check("alt_instr_pc", a_instr_pc, 64'h400);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
